// File: rtl/spi_baud_generator.sv
// SPI baud generator: divides PCLK down to SCLK, emits one-cycle sample and
// shift strobes on each SCLK edge and a byte_done pulse after every 16 edges.
// Optional feature: define SPI_BAUD_LATCH_EN to freeze sppr/spr for the whole
// enabled period. When it is not defined, the live values are used every cycle.
module spi_baud_generator (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [1:0]  spi_mode,
  input  logic        spiswai,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        ss,
  input  logic [2:0]  sppr,
  input  logic [2:0]  spr,
  output logic        sclk,
  output logic        sample_strobe,
  output logic        shift_strobe,
  output logic        byte_done,
  output logic [11:0] baud_divisor
);

  logic        en;
  logic [2:0]  eff_sppr;
  logic [2:0]  eff_spr;
  logic [10:0] prescale;
  logic [10:0] half;
  logic        edge_hit;
  logic        leading;

  logic [10:0] cnt_q, cnt_d;
  logic        sclk_q, sclk_d;
  logic [3:0]  edge_cnt_q, edge_cnt_d;

  // Run mode, or wait mode with SCLK not stopped, while the slave is selected.
  assign en = !ss && ((spi_mode == 2'b00) || ((spi_mode == 2'b01) && !spiswai));

`ifdef SPI_BAUD_LATCH_EN
  logic       en_q;
  logic [2:0] sppr_q, sppr_d;
  logic [2:0] spr_q, spr_d;

  // Capture the rate settings on the cycle enable rises.
  always_comb begin
    sppr_d = sppr_q;
    spr_d  = spr_q;
    if (en && !en_q) begin
      sppr_d = sppr;
      spr_d  = spr;
    end
  end

  // Latched rate registers and enable history.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q   <= 1'b0;
      sppr_q <= 3'd0;
      spr_q  <= 3'd0;
    end else begin
      en_q   <= en;
      sppr_q <= sppr_d;
      spr_q  <= spr_d;
    end
  end

  // The rising cycle itself still uses the live inputs (they are being captured).
  always_comb begin
    eff_sppr = sppr;
    eff_spr  = spr;
    if (en && en_q) begin
      eff_sppr = sppr_q;
      eff_spr  = spr_q;
    end
  end
`else
  // Live rate settings; a shrinking H is absorbed by the >= compare below.
  always_comb begin
    eff_sppr = sppr;
    eff_spr  = spr;
  end
`endif

  // Half period H = (sppr+1) << spr (1..1024), full divisor is 2*H (2..2048).
  always_comb begin
    prescale     = {8'd0, eff_sppr} + 11'd1;
    half         = prescale << eff_spr;
    baud_divisor = {1'b0, half} << 1;
  end

  // Edge detection and strobe decode; strobes are held low during reset.
  always_comb begin
    edge_hit      = en && (cnt_q >= (half - 11'd1));
    leading       = (sclk_q == cpol);
    sample_strobe = !PRESET && edge_hit && (leading != cpha);
    shift_strobe  = !PRESET && edge_hit && (leading == cpha);
    byte_done     = !PRESET && edge_hit && (edge_cnt_q == 4'hF);
  end

  // Next-state for the divider counter, SCLK level and edge counter.
  always_comb begin
    cnt_d      = cnt_q;
    sclk_d     = sclk_q;
    edge_cnt_d = edge_cnt_q;
    if (!en) begin
      cnt_d      = 11'd0;
      sclk_d     = cpol;
      edge_cnt_d = 4'd0;
    end else if (edge_hit) begin
      cnt_d      = 11'd0;
      sclk_d     = !sclk_q;
      edge_cnt_d = edge_cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q + 11'd1;
    end
  end

  // State registers; reset forces SCLK low regardless of cpol.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q      <= 11'd0;
      sclk_q     <= 1'b0;
      edge_cnt_q <= 4'd0;
    end else begin
      cnt_q      <= cnt_d;
      sclk_q     <= sclk_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Self-checking bench for spi_baud_generator: divisor table, directed
// multi-cycle sequences, then randomized runs against a timing model.
module tb_spi_baud_generator;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  spi_mode;
  logic        spiswai;
  logic        cpol;
  logic        cpha;
  logic        ss;
  logic [2:0]  sppr;
  logic [2:0]  spr;
  logic        sclk;
  logic        sample_strobe;
  logic        shift_strobe;
  logic        byte_done;
  logic [11:0] baud_divisor;

  int vectors;
  int miscompares;

  // Reference model state: cycles since enable rose, and expected SCLK register.
  int   t_m;
  logic sclk_m;

  spi_baud_generator dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .spi_mode     (spi_mode),
    .spiswai      (spiswai),
    .cpol         (cpol),
    .cpha         (cpha),
    .ss           (ss),
    .sppr         (sppr),
    .spr          (spr),
    .sclk         (sclk),
    .sample_strobe(sample_strobe),
    .shift_strobe (shift_strobe),
    .byte_done    (byte_done),
    .baud_divisor (baud_divisor)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  typedef struct {
    logic [2:0] sppr;
    logic [2:0] spr;
    int         exp_div;
  } div_vec_t;

  div_vec_t dv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One cycle of model-checked operation; inputs must stay stable meanwhile.
  task automatic model_cycle();
    int  h;
    bit  en_m;
    bit  edge_m;
    bit  lead_m;
    bit  samp_e;
    bit  shift_e;
    bit  done_e;
    @(negedge PCLK);
    h      = (int'(sppr) + 1) << spr;
    en_m   = !ss && (spi_mode == 2'b00 || (spi_mode == 2'b01 && !spiswai));
    edge_m = en_m && (((t_m + 1) % h) == 0);
    lead_m = (sclk_m == cpol);
    samp_e = edge_m && (lead_m ? !cpha : cpha);
    shift_e = edge_m && (lead_m ? cpha : !cpha);
    done_e = edge_m && ((((t_m + 1) / h) % 16) == 0);
    chk("rnd_sclk", sclk, sclk_m);
    chk("rnd_sample", sample_strobe, samp_e);
    chk("rnd_shift", shift_strobe, shift_e);
    chk("rnd_byte_done", byte_done, done_e);
    chk("rnd_divisor", baud_divisor, 2 * h);
    if (en_m) begin
      if (edge_m) sclk_m = !sclk_m;
      t_m++;
    end else begin
      t_m    = 0;
      sclk_m = cpol;
    end
    tick();
  endtask

  initial begin
    int r;
    vectors     = 0;
    miscompares = 0;

    dv[0] = '{sppr: 3'd0, spr: 3'd0, exp_div: 2};
    dv[1] = '{sppr: 3'd2, spr: 3'd1, exp_div: 12};
    dv[2] = '{sppr: 3'd7, spr: 3'd7, exp_div: 2048};
    dv[3] = '{sppr: 3'd0, spr: 3'd7, exp_div: 256};
    dv[4] = '{sppr: 3'd7, spr: 3'd0, exp_div: 16};
    dv[5] = '{sppr: 3'd3, spr: 3'd2, exp_div: 32};
    dv[6] = '{sppr: 3'd1, spr: 3'd3, exp_div: 32};
    dv[7] = '{sppr: 3'd4, spr: 3'd4, exp_div: 160};

    // Reset with cpol=1: SCLK still forced low.
    PRESET = 1'b1; spi_mode = 2'b00; spiswai = 1'b0; cpol = 1'b1; cpha = 1'b0;
    ss = 1'b1; sppr = 3'd0; spr = 3'd0;
    tick(); tick();
    @(negedge PCLK);
    chk("reset_sclk", sclk, 0);
    chk("reset_sample", sample_strobe, 0);
    chk("reset_shift", shift_strobe, 0);
    chk("reset_byte_done", byte_done, 0);

    // Divisor table, combinational even in reset.
    for (int i = 0; i < 8; i++) begin
      sppr = dv[i].sppr;
      spr  = dv[i].spr;
      #1;
      chk("divisor_table", baud_divisor, dv[i].exp_div);
    end
    sppr = 3'd0; spr = 3'd0;

    // Release: SCLK picks up cpol on the first clock.
    tick();
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("post_reset_sclk_before", sclk, 0);
    tick();
    @(negedge PCLK);
    chk("post_reset_sclk_follow", sclk, 1);
    // cpol change while idle appears one cycle later.
    tick();
    cpol = 1'b0;
    @(negedge PCLK);
    chk("cpol_idle_same", sclk, 1);
    tick();
    @(negedge PCLK);
    chk("cpol_idle_next", sclk, 0);
    tick();

    // H=1: toggle every cycle, alternating strobes, byte_done on the 16th cycle.
    ss = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge PCLK);
      chk("h1_sclk", sclk, j % 2);
      chk("h1_sample", sample_strobe, (j % 2) == 0);
      chk("h1_shift", shift_strobe, (j % 2) == 1);
      chk("h1_byte_done", byte_done, j == 15);
      tick();
    end

    // sppr=2, spr=1: H=6, period 12.
    ss = 1'b1; sppr = 3'd2; spr = 3'd1;
    tick();
    @(negedge PCLK);
    chk("h6_divisor", baud_divisor, 12);
    tick();
    ss = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge PCLK);
      chk("h6_sclk", sclk, (j / 6) % 2);
      chk("h6_sample", sample_strobe, (j % 6 == 5) && ((j / 6) % 2 == 0));
      chk("h6_shift", shift_strobe, (j % 6 == 5) && ((j / 6) % 2 == 1));
      tick();
    end

    // cpol=1, cpha=1, H=2: first (falling) edge shifts, second (rising) samples.
    ss = 1'b1; cpol = 1'b1; cpha = 1'b1; sppr = 3'd1; spr = 3'd0;
    tick();
    ss = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge PCLK);
      chk("m3_sclk", sclk, 1 ^ ((j / 2) % 2));
      chk("m3_shift", shift_strobe, (j % 4) == 1);
      chk("m3_sample", sample_strobe, (j % 4) == 3);
      tick();
    end

    // Wait mode with spiswai asserted mid-byte freezes SCLK, restart from edge 0.
    ss = 1'b1; cpol = 1'b0; cpha = 1'b0; spi_mode = 2'b01; spiswai = 1'b0;
    tick();
    ss = 1'b0;
    repeat (6) tick();
    spiswai = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      if (k > 0) chk("wait_sclk_frozen", sclk, 0);
      chk("wait_no_strobe", sample_strobe | shift_strobe, 0);
      chk("wait_no_done", byte_done, 0);
      tick();
    end
    spiswai = 1'b0;
    for (int j = 0; j < 32; j++) begin
      @(negedge PCLK);
      chk("wait_resume_sclk", sclk, (j / 2) % 2);
      chk("wait_resume_done", byte_done, j == 31);
      tick();
    end

    // PRESET pulse at edge 7 of a byte, then a clean new byte.
    ss = 1'b1; spi_mode = 2'b00; sppr = 3'd0; spr = 3'd0;
    tick();
    ss = 1'b0;
    for (int j = 0; j < 7; j++) begin
      @(negedge PCLK);
      chk("pre_rst_sclk", sclk, j % 2);
      tick();
    end
    PRESET = 1'b1;
    #1;
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_strobes", sample_strobe | shift_strobe, 0);
    chk("mid_rst_done", byte_done, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge PCLK);
      chk("hold_rst_sclk", sclk, 0);
      chk("hold_rst_done", byte_done, 0);
      tick();
    end
    PRESET = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge PCLK);
      chk("after_rst_sclk", sclk, j % 2);
      chk("after_rst_done", byte_done, j == 15);
      tick();
    end

    // spr changed 0->3 mid-byte.
    ss = 1'b1;
    tick();
    ss = 1'b0;
    for (int j = 0; j < 13; j++) begin
      if (j == 4) spr = 3'd3;
      @(negedge PCLK);
      if (j < 4) begin
        chk("spr_chg_pre_sclk", sclk, j % 2);
      end else begin
`ifdef SPI_BAUD_LATCH_EN
        chk("spr_chg_sclk", sclk, j % 2);
        chk("spr_chg_strobe", sample_strobe | shift_strobe, 1);
        chk("spr_chg_divisor", baud_divisor, 2);
`else
        chk("spr_chg_sclk", sclk, j == 12);
        chk("spr_chg_strobe", sample_strobe | shift_strobe, j == 11);
        chk("spr_chg_divisor", baud_divisor, 16);
`endif
      end
      tick();
    end

    // Randomized runs; rate and polarity only change while deselected.
    ss = 1'b1; spr = 3'd0;
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    t_m    = 0;
    sclk_m = 1'b0;
    repeat (60) begin
      ss   = 1'b1;
      sppr = 3'($urandom_range(0, 7));
      spr  = 3'($urandom_range(0, 3));
      cpol = 1'($urandom_range(0, 1));
      cpha = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 9));
      spi_mode = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      spiswai  = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 3)) model_cycle();
      ss = 1'b0;
      repeat ($urandom_range(10, 80)) begin
        model_cycle();
        if ($urandom_range(0, 39) == 0) spiswai = !spiswai;
        if ($urandom_range(0, 59) == 0) ss = !ss;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
